// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing signal bundle of the branch predict unit: IF lookup, EX resolution
// and the statistics outputs. The pipeline is master, the unit is slave.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_stall;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic [31:0]      ex_pc;
    logic             ex_pred_taken;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             branch_taken;
    logic             mispredict;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_opcode, ex_funct3, ex_pc,
               ex_pred_taken, rs1_data, rs2_data,
        input  if_pred_taken, branch_taken, mispredict, stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_opcode, ex_funct3, ex_pc,
               ex_pred_taken, rs1_data, rs2_data,
        output if_pred_taken, branch_taken, mispredict, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predict_unit.sv
// RV32I branch resolution in EX, bimodal 2-bit BHT prediction in IF, and
// saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 64,
    parameter int IDX_W        = $clog2(BHT_ENTRIES),
    parameter int PREDICT_MODE = 1,
    parameter int CNT_W        = 32
) (
    input logic clk,
    input logic rst,
    branch_predict_unit_if.slave bus
);
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;

    // An EX instruction is consumed only when ex_valid is high and ex_stall is low;
    // there is no backpressure from this unit, so a resolve is a single-cycle event.
    logic             resolve;
    logic             cond_true;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [CNT_W-1:0] cnt_branches;
    logic [CNT_W-1:0] cnt_mispredicts;

    assign rs1     = bus.rs1_data;
    assign rs2     = bus.rs2_data;
    assign resolve = bus.ex_valid & ~bus.ex_stall & (bus.ex_opcode == OP_B_TYPE);

    always_comb begin
        cond_true = 1'b0;
        case (bus.ex_funct3)
            3'b000:  cond_true = (rs1 == rs2);
            3'b001:  cond_true = (rs1 != rs2);
            3'b100:  cond_true = ($signed(rs1) <  $signed(rs2));
            3'b101:  cond_true = ($signed(rs1) >= $signed(rs2));
            3'b110:  cond_true = (rs1 <  rs2);
            3'b111:  cond_true = (rs1 >= rs2);
            default: cond_true = 1'b0;
        endcase
    end

    assign bus.branch_taken = resolve & cond_true;
    assign bus.mispredict   = resolve & (cond_true != bus.ex_pred_taken);

    generate
        if (PREDICT_MODE == 1) begin : g_bht
            logic [1:0]       bht [BHT_ENTRIES];
            logic [IDX_W-1:0] rd_idx;
            logic [IDX_W-1:0] wr_idx;
            logic             unused_pc;

            assign rd_idx    = bus.if_pc[IDX_W+1:2];
            assign wr_idx    = bus.ex_pc[IDX_W+1:2];
            assign unused_pc = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                                 bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
                end else if (resolve) begin
                    if (cond_true) begin
                        if (bht[wr_idx] != 2'b11) bht[wr_idx] <= bht[wr_idx] + 2'd1;
                    end else begin
                        if (bht[wr_idx] != 2'b00) bht[wr_idx] <= bht[wr_idx] - 2'd1;
                    end
                end
            end

            // Read returns the stored value; a same-cycle update shows up next cycle.
            assign bus.if_pred_taken = bht[rd_idx][1];
        end else begin : g_static
            logic unused_pc;
            assign unused_pc         = ^{bus.if_pc, bus.ex_pc};
            assign bus.if_pred_taken = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else begin
            if (resolve && (cnt_branches != '1))
                cnt_branches <= cnt_branches + CNT_W'(1);
            if (bus.mispredict && (cnt_mispredicts != '1))
                cnt_mispredicts <= cnt_mispredicts + CNT_W'(1);
        end
    end

    assign bus.stat_branches    = cnt_branches;
    assign bus.stat_mispredicts = cnt_mispredicts;
endmodule
